// File: rtl/mem_port_arbiter_if.sv
// AXI4 bus bundle shared by the CPU port, the SD DMA port and the MIG port.
// Valid/ready rule on every channel: a transfer happens in the cycle where
// both valid and ready are high; once valid rises it stays high, with its
// payload stable, until that transfer.
interface mem_port_arbiter_if #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [5:0]              aw_atop;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Weighted round-robin arbiter sharing the MIG AXI4 port between the CPU
// path (port 0) and the SD DMA master (port 1). The winning port index is
// prefixed onto the ID; R/B come back by that ID bit, W follows AW order
// through a small grant FIFO.
module mem_port_arbiter #(
    parameter int unsigned SLV_ID_WIDTH   = 4,
    parameter int unsigned MST_ID_WIDTH   = 5,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned WEIGHT0        = 4,
    parameter int unsigned WEIGHT1        = 1,
    parameter int unsigned MAX_R_TRANS    = 8,
    parameter int unsigned MAX_W_TRANS    = 4
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    mem_port_arbiter_if.slave                 slv0,
    mem_port_arbiter_if.slave                 slv1,
    mem_port_arbiter_if.master                mst,
    output logic                              dbg_ar_state,
    output logic                              dbg_aw_state,
    output logic [$clog2(MAX_R_TRANS+1)-1:0]  dbg_rd_out,
    output logic [$clog2(MAX_W_TRANS+1)-1:0]  dbg_w_count
);
    localparam int CW  = 8;
    localparam int RDW = $clog2(MAX_R_TRANS + 1);
    localparam int PW  = (MAX_W_TRANS > 1) ? $clog2(MAX_W_TRANS) : 1;
    localparam int FCW = $clog2(MAX_W_TRANS + 1);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    state_e              ar_state_q, ar_state_d, aw_state_q, aw_state_d;
    logic                ar_gnt_q, ar_gnt_d, aw_gnt_q, aw_gnt_d;
    logic                ar_p_q, ar_p_d, aw_p_q, aw_p_d;
    logic [CW-1:0]       ar_cnt_q, ar_cnt_d, aw_cnt_q, aw_cnt_d;
    logic [RDW-1:0]      rd_out_q, rd_out_d;
    logic [MAX_W_TRANS-1:0] wq_q, wq_d;
    logic [PW-1:0]       w_wr_ptr_q, w_wr_ptr_d, w_rd_ptr_q, w_rd_ptr_d;
    logic [FCW-1:0]      w_cnt_q, w_cnt_d;

    logic ar_hs, aw_hs, r_done, w_pop, ar_blocked, aw_blocked, w_head, w_nonempty;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_sel, aw_addr_sel;
    logic [AXI_DATA_WIDTH-1:0] w_data_sel;

    // Weighted choice: a lone requester wins without touching the weight
    // state; under contention the preferred port wins until its weight runs out.
    function automatic void pick(input logic req0, input logic req1, input logic p,
                                 input logic [CW-1:0] cnt, output logic g,
                                 output logic p_n, output logic [CW-1:0] cnt_n);
        logic [CW-1:0] weight;
        weight = p ? CW'(WEIGHT1) : CW'(WEIGHT0);
        g      = req1 & ~req0;
        p_n    = p;
        cnt_n  = cnt;
        if (req0 && req1) begin
            g = p;
            if (cnt + CW'(1) == weight) begin
                p_n   = ~p;
                cnt_n = '0;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end
    endfunction

    assign ar_hs      = mst.ar_valid & mst.ar_ready;
    assign aw_hs      = mst.aw_valid & mst.aw_ready;
    assign r_done     = mst.r_valid & mst.r_ready & mst.r_last;
    assign w_pop      = mst.w_valid & mst.w_ready & mst.w_last;
    assign ar_blocked = (rd_out_q == RDW'(MAX_R_TRANS));
    assign aw_blocked = (w_cnt_q == FCW'(MAX_W_TRANS));
    assign w_head     = wq_q[w_rd_ptr_q];
    assign w_nonempty = (w_cnt_q != '0);

    // AR grant FSM next state: grant in IDLE, hold until the MIG accepts
    always_comb begin
        ar_state_d = ar_state_q;
        ar_gnt_d   = ar_gnt_q;
        ar_p_d     = ar_p_q;
        ar_cnt_d   = ar_cnt_q;
        case (ar_state_q)
            IDLE: if (!ar_blocked && (slv0.ar_valid || slv1.ar_valid)) begin
                pick(slv0.ar_valid, slv1.ar_valid, ar_p_q, ar_cnt_q, ar_gnt_d, ar_p_d, ar_cnt_d);
                ar_state_d = HOLD;
            end
            HOLD: if (ar_hs) ar_state_d = IDLE;
            default: ar_state_d = IDLE;
        endcase
    end

    // AW grant FSM next state: same shape, blocked by a full W route FIFO
    always_comb begin
        aw_state_d = aw_state_q;
        aw_gnt_d   = aw_gnt_q;
        aw_p_d     = aw_p_q;
        aw_cnt_d   = aw_cnt_q;
        case (aw_state_q)
            IDLE: if (!aw_blocked && (slv0.aw_valid || slv1.aw_valid)) begin
                pick(slv0.aw_valid, slv1.aw_valid, aw_p_q, aw_cnt_q, aw_gnt_d, aw_p_d, aw_cnt_d);
                aw_state_d = HOLD;
            end
            HOLD: if (aw_hs) aw_state_d = IDLE;
            default: aw_state_d = IDLE;
        endcase
    end

    // Outstanding read bursts and the W route FIFO bookkeeping
    always_comb begin
        rd_out_d   = rd_out_q;
        wq_d       = wq_q;
        w_wr_ptr_d = w_wr_ptr_q;
        w_rd_ptr_d = w_rd_ptr_q;
        w_cnt_d    = w_cnt_q;
        case ({ar_hs, r_done})
            2'b10:   rd_out_d = rd_out_q + RDW'(1);
            2'b01:   rd_out_d = rd_out_q - RDW'(1);
            default: rd_out_d = rd_out_q;
        endcase
        if (aw_hs) begin
            wq_d[w_wr_ptr_q] = aw_gnt_q;
            w_wr_ptr_d       = w_wr_ptr_q + PW'(1);
        end
        if (w_pop) w_rd_ptr_d = w_rd_ptr_q + PW'(1);
        case ({aw_hs, w_pop})
            2'b10:   w_cnt_d = w_cnt_q + FCW'(1);
            2'b01:   w_cnt_d = w_cnt_q - FCW'(1);
            default: w_cnt_d = w_cnt_q;
        endcase
    end

    // All state registers; reset discards any in-flight bursts
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ar_state_q <= IDLE;
            aw_state_q <= IDLE;
            ar_gnt_q   <= 1'b0;
            aw_gnt_q   <= 1'b0;
            ar_p_q     <= 1'b0;
            aw_p_q     <= 1'b0;
            ar_cnt_q   <= '0;
            aw_cnt_q   <= '0;
            rd_out_q   <= '0;
            wq_q       <= '0;
            w_wr_ptr_q <= '0;
            w_rd_ptr_q <= '0;
            w_cnt_q    <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            aw_state_q <= aw_state_d;
            ar_gnt_q   <= ar_gnt_d;
            aw_gnt_q   <= aw_gnt_d;
            ar_p_q     <= ar_p_d;
            aw_p_q     <= aw_p_d;
            ar_cnt_q   <= ar_cnt_d;
            aw_cnt_q   <= aw_cnt_d;
            rd_out_q   <= rd_out_d;
            wq_q       <= wq_d;
            w_wr_ptr_q <= w_wr_ptr_d;
            w_rd_ptr_q <= w_rd_ptr_d;
            w_cnt_q    <= w_cnt_d;
        end
    end

    // AR channel: granted port's request passes through while holding
    assign ar_addr_sel   = ar_gnt_q ? slv1.ar_addr : slv0.ar_addr;
    assign mst.ar_valid  = (ar_state_q == HOLD);
    assign mst.ar_id     = {ar_gnt_q, ar_gnt_q ? slv1.ar_id : slv0.ar_id};
    assign mst.ar_addr   = ar_addr_sel;
    assign mst.ar_len    = ar_gnt_q ? slv1.ar_len    : slv0.ar_len;
    assign mst.ar_size   = ar_gnt_q ? slv1.ar_size   : slv0.ar_size;
    assign mst.ar_burst  = ar_gnt_q ? slv1.ar_burst  : slv0.ar_burst;
    assign mst.ar_lock   = ar_gnt_q ? slv1.ar_lock   : slv0.ar_lock;
    assign mst.ar_cache  = ar_gnt_q ? slv1.ar_cache  : slv0.ar_cache;
    assign mst.ar_prot   = ar_gnt_q ? slv1.ar_prot   : slv0.ar_prot;
    assign mst.ar_qos    = ar_gnt_q ? slv1.ar_qos    : slv0.ar_qos;
    assign mst.ar_region = ar_gnt_q ? slv1.ar_region : slv0.ar_region;
    assign mst.ar_user   = ar_gnt_q ? slv1.ar_user   : slv0.ar_user;
    assign slv0.ar_ready = mst.ar_valid & ~ar_gnt_q & mst.ar_ready;
    assign slv1.ar_ready = mst.ar_valid &  ar_gnt_q & mst.ar_ready;

    // AW channel: same pass-through as AR
    assign aw_addr_sel   = aw_gnt_q ? slv1.aw_addr : slv0.aw_addr;
    assign mst.aw_valid  = (aw_state_q == HOLD);
    assign mst.aw_id     = {aw_gnt_q, aw_gnt_q ? slv1.aw_id : slv0.aw_id};
    assign mst.aw_addr   = aw_addr_sel;
    assign mst.aw_len    = aw_gnt_q ? slv1.aw_len    : slv0.aw_len;
    assign mst.aw_size   = aw_gnt_q ? slv1.aw_size   : slv0.aw_size;
    assign mst.aw_burst  = aw_gnt_q ? slv1.aw_burst  : slv0.aw_burst;
    assign mst.aw_lock   = aw_gnt_q ? slv1.aw_lock   : slv0.aw_lock;
    assign mst.aw_cache  = aw_gnt_q ? slv1.aw_cache  : slv0.aw_cache;
    assign mst.aw_prot   = aw_gnt_q ? slv1.aw_prot   : slv0.aw_prot;
    assign mst.aw_qos    = aw_gnt_q ? slv1.aw_qos    : slv0.aw_qos;
    assign mst.aw_region = aw_gnt_q ? slv1.aw_region : slv0.aw_region;
    assign mst.aw_atop   = aw_gnt_q ? slv1.aw_atop   : slv0.aw_atop;
    assign mst.aw_user   = aw_gnt_q ? slv1.aw_user   : slv0.aw_user;
    assign slv0.aw_ready = mst.aw_valid & ~aw_gnt_q & mst.aw_ready;
    assign slv1.aw_ready = mst.aw_valid &  aw_gnt_q & mst.aw_ready;

    // W channel: FIFO head picks which port's data goes to the MIG
    assign w_data_sel   = w_head ? slv1.w_data : slv0.w_data;
    assign mst.w_data   = w_data_sel;
    assign mst.w_strb   = w_head ? slv1.w_strb : slv0.w_strb;
    assign mst.w_last   = w_head ? slv1.w_last : slv0.w_last;
    assign mst.w_user   = w_head ? slv1.w_user : slv0.w_user;
    assign mst.w_valid  = w_nonempty & (w_head ? slv1.w_valid : slv0.w_valid);
    assign slv0.w_ready = w_nonempty & ~w_head & mst.w_ready;
    assign slv1.w_ready = w_nonempty &  w_head & mst.w_ready;

    // R and B: routed back by the port bit prepended to the ID
    assign slv0.r_valid = mst.r_valid & ~mst.r_id[MST_ID_WIDTH-1];
    assign slv1.r_valid = mst.r_valid &  mst.r_id[MST_ID_WIDTH-1];
    assign slv0.r_id    = mst.r_id[SLV_ID_WIDTH-1:0];
    assign slv1.r_id    = mst.r_id[SLV_ID_WIDTH-1:0];
    assign slv0.r_data  = mst.r_data;
    assign slv1.r_data  = mst.r_data;
    assign slv0.r_resp  = mst.r_resp;
    assign slv1.r_resp  = mst.r_resp;
    assign slv0.r_last  = mst.r_last;
    assign slv1.r_last  = mst.r_last;
    assign slv0.r_user  = mst.r_user;
    assign slv1.r_user  = mst.r_user;
    assign mst.r_ready  = mst.r_valid & (mst.r_id[MST_ID_WIDTH-1] ? slv1.r_ready : slv0.r_ready);

    assign slv0.b_valid = mst.b_valid & ~mst.b_id[MST_ID_WIDTH-1];
    assign slv1.b_valid = mst.b_valid &  mst.b_id[MST_ID_WIDTH-1];
    assign slv0.b_id    = mst.b_id[SLV_ID_WIDTH-1:0];
    assign slv1.b_id    = mst.b_id[SLV_ID_WIDTH-1:0];
    assign slv0.b_resp  = mst.b_resp;
    assign slv1.b_resp  = mst.b_resp;
    assign slv0.b_user  = mst.b_user;
    assign slv1.b_user  = mst.b_user;
    assign mst.b_ready  = mst.b_valid & (mst.b_id[MST_ID_WIDTH-1] ? slv1.b_ready : slv0.b_ready);

    assign dbg_ar_state = (ar_state_q == HOLD);
    assign dbg_aw_state = (aw_state_q == HOLD);
    assign dbg_rd_out   = rd_out_q;
    assign dbg_w_count  = w_cnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: weighted grant order, read-outstanding
// limit, W routing order, W FIFO full stall, response routing and reset.
module tb_mem_port_arbiter;
    logic       clk = 1'b0;
    logic       aresetn;
    logic       dbg_ar_state, dbg_aw_state;
    logic [3:0] dbg_rd_out;
    logic [2:0] dbg_w_count;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    int i0, i1;

    mem_port_arbiter_if #(.ID_WIDTH(4)) s0 ();
    mem_port_arbiter_if #(.ID_WIDTH(4)) s1 ();
    mem_port_arbiter_if #(.ID_WIDTH(5)) m ();

    mem_port_arbiter dut (
        .aclk         (clk),
        .aresetn      (aresetn),
        .slv0         (s0),
        .slv1         (s1),
        .mst          (m),
        .dbg_ar_state (dbg_ar_state),
        .dbg_aw_state (dbg_aw_state),
        .dbg_rd_out   (dbg_rd_out),
        .dbg_w_count  (dbg_w_count)
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_w();
        s0.w_valid = (i0 < 4);
        s0.w_data  = 32'hA0 + 32'(i0);
        s0.w_last  = (i0 == 3);
        s1.w_valid = (i1 < 2);
        s1.w_data  = 32'hB0 + 32'(i1);
        s1.w_last  = (i1 == 1);
    endtask

    // Collect n AR grants, checking each ID against exp_q; each granted
    // read is retired with a one-beat R in the cycle after its handshake.
    task automatic ar_collect(input int n, input string tag);
        int got = 0;
        logic hs_prev = 1'b0;
        logic [4:0] prev_id = '0;
        logic [31:0] e;
        for (int c = 0; c < 8 * n + 8 && got < n; c++) begin
            m.r_valid = hs_prev;
            m.r_id    = prev_id;
            m.r_last  = 1'b1;
            if (m.ar_valid && m.ar_ready) begin
                e = exp_q.pop_front();
                chk(tag, 32'(m.ar_id), e);
                chk({tag, "_rdy"}, {30'd0, s1.ar_ready, s0.ar_ready}, e[4] ? 32'd2 : 32'd1);
                hs_prev = 1'b1;
                prev_id = m.ar_id;
                got++;
            end else begin
                hs_prev = 1'b0;
            end
            tick();
        end
        chk({tag, "_cnt"}, 32'(got), 32'(n));
        s0.ar_valid = 1'b0;
        s1.ar_valid = 1'b0;
        m.r_valid   = hs_prev;
        m.r_id      = prev_id;
        tick();
        m.r_valid   = 1'b0;
        chk({tag, "_rd_out"}, 32'(dbg_rd_out), 32'd0);
    endtask

    initial begin
        int n, naw, nw;
        logic hs0, hs1, w0, w1;

        // reset and idle inputs
        aresetn = 1'b0;
        s0.ar_valid = 0; s1.ar_valid = 0; s0.aw_valid = 0; s1.aw_valid = 0;
        s0.ar_id = 4'h3; s1.ar_id = 4'h9; s0.ar_len = 0; s1.ar_len = 0;
        s0.aw_id = 4'h2; s1.aw_id = 4'h5; s0.aw_len = 8'd3; s1.aw_len = 8'd1;
        s0.w_valid = 0; s1.w_valid = 0; s0.w_last = 0; s1.w_last = 0;
        s0.w_data = 0; s1.w_data = 0; s0.w_strb = 4'hF; s1.w_strb = 4'hF;
        s0.r_ready = 1; s1.r_ready = 1; s0.b_ready = 1; s1.b_ready = 1;
        m.ar_ready = 0; m.aw_ready = 0; m.w_ready = 0;
        m.r_valid = 0; m.r_id = 0; m.r_last = 0; m.r_data = 0; m.r_resp = 0;
        m.b_valid = 0; m.b_id = 0; m.b_resp = 0;
        tick(); tick();
        chk("rst_ar_valid", 32'(m.ar_valid), 0);
        chk("rst_aw_valid", 32'(m.aw_valid), 0);
        chk("rst_w_valid",  32'(m.w_valid), 0);
        chk("rst_r_ready",  32'(m.r_ready), 0);
        chk("rst_b_ready",  32'(m.b_ready), 0);
        chk("rst_slv_ready", {26'd0, s0.ar_ready, s1.ar_ready, s0.aw_ready, s1.aw_ready, s0.w_ready, s1.w_ready}, 0);
        chk("rst_rd_out",   32'(dbg_rd_out), 0);
        chk("rst_w_count",  32'(dbg_w_count), 0);

        // both ports contend: order 0,0,0,0,1 repeating
        aresetn = 1'b1;
        m.ar_ready = 1'b1;
        s0.ar_valid = 1'b1;
        s1.ar_valid = 1'b1;
        for (int k = 0; k < 10; k++) exp_q.push_back((k % 5 == 4) ? 32'h19 : 32'h03);
        ar_collect(10, "wrr");

        // port 1 alone: weight state untouched, next contended grant is port 0
        s1.ar_valid = 1'b1;
        repeat (3) exp_q.push_back(32'h19);
        ar_collect(3, "p1only");
        s0.ar_valid = 1'b1;
        s1.ar_valid = 1'b1;
        exp_q.push_back(32'h03);
        ar_collect(1, "after_p1");

        // R routing by ID bit
        m.r_valid = 1'b1; m.r_id = 5'h1a; m.r_last = 1'b0; m.r_data = 32'h1234;
        #1;
        chk("r_route_v", {30'd0, s1.r_valid, s0.r_valid}, 32'd2);
        chk("r_route_id", 32'(s1.r_id), 32'ha);
        chk("r_route_data", s1.r_data, 32'h1234);
        chk("r_ready_fwd", 32'(m.r_ready), 1);
        s1.r_ready = 1'b0;
        #1;
        chk("r_ready_hold", 32'(m.r_ready), 0);
        m.r_valid = 1'b0; s1.r_ready = 1'b1; m.r_last = 1'b1;
        tick();

        // read limit: 8 outstanding, then blocked until one burst returns
        s0.ar_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (m.ar_valid && m.ar_ready) n++;
            tick();
        end
        chk("blk_count", 32'(n), 8);
        chk("blk_rd_out", 32'(dbg_rd_out), 8);
        chk("blk_stall", 32'(m.ar_valid), 0);
        m.r_valid = 1'b1; m.r_id = 5'h03; m.r_last = 1'b1;
        tick();
        m.r_valid = 1'b0;
        chk("blk_gap", 32'(m.ar_valid), 0);
        tick();
        chk("blk_9th_valid", 32'(m.ar_valid), 1);
        chk("blk_9th_ready", 32'(s0.ar_ready), 1);
        tick();
        chk("blk_rd_out_9", 32'(dbg_rd_out), 8);
        s0.ar_valid = 1'b0;
        m.r_valid = 1'b1;
        repeat (8) tick();
        m.r_valid = 1'b0;
        chk("blk_drain", 32'(dbg_rd_out), 0);

        // W order follows AW order: port 0's 4 beats then port 1's 2 beats
        m.aw_ready = 1'b1; m.w_ready = 1'b1;
        s0.aw_valid = 1'b1; s1.aw_valid = 1'b1;
        i0 = 0; i1 = 0;
        drive_w();
        exp_q.push_back(32'h000A0); exp_q.push_back(32'h000A1);
        exp_q.push_back(32'h000A2); exp_q.push_back(32'h100A3);
        exp_q.push_back(32'h000B0); exp_q.push_back(32'h100B1);
        naw = 0; nw = 0;
        #1;
        for (int c = 0; c < 40 && nw < 6; c++) begin
            hs0 = s0.aw_valid && s0.aw_ready;
            hs1 = s1.aw_valid && s1.aw_ready;
            w0  = s0.w_valid && s0.w_ready;
            w1  = s1.w_valid && s1.w_ready;
            if (m.aw_valid && m.aw_ready) begin
                chk("aw_id", 32'(m.aw_id), (naw == 0) ? 32'h02 : 32'h15);
                naw++;
            end
            if (m.w_valid && m.w_ready) begin
                chk("w_beat", {15'd0, m.w_last, m.w_data[15:0]}, exp_q.pop_front());
                chk("w_route", {30'd0, s1.w_ready, s0.w_ready}, (nw < 4) ? 32'd1 : 32'd2);
                nw++;
            end
            tick();
            if (hs0) s0.aw_valid = 1'b0;
            if (hs1) s1.aw_valid = 1'b0;
            if (w0) i0++;
            if (w1) i1++;
            drive_w();
            #1;
        end
        chk("w_beats", 32'(nw), 6);
        chk("aw_count", 32'(naw), 2);
        chk("w_fifo_empty", 32'(dbg_w_count), 0);

        // B routing by ID bit
        m.b_valid = 1'b1; m.b_id = 5'h15; m.b_resp = 2'b10;
        #1;
        chk("b_route_v", {30'd0, s1.b_valid, s0.b_valid}, 32'd2);
        chk("b_route_id", 32'(s1.b_id), 32'h5);
        chk("b_route_resp", 32'(s1.b_resp), 32'h2);
        chk("b_ready_fwd", 32'(m.b_ready), 1);
        m.b_valid = 1'b0;
        tick();

        // W FIFO full: 4 AWs accepted, 5th stalls until one burst drains
        m.w_ready = 1'b0;
        s0.aw_len = 8'd0;
        s0.aw_valid = 1'b1;
        s0.w_valid = 1'b1; s0.w_last = 1'b1; s0.w_data = 32'h55;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (m.aw_valid && m.aw_ready) n++;
            tick();
        end
        chk("full_count", 32'(n), 4);
        chk("full_w_count", 32'(dbg_w_count), 4);
        chk("full_stall", 32'(m.aw_valid), 0);
        m.w_ready = 1'b1;
        tick();
        m.w_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (m.aw_valid && m.aw_ready) n++;
            tick();
        end
        chk("full_5th", 32'(n), 1);
        chk("full_w_count2", 32'(dbg_w_count), 4);

        // reset while both channels hold a grant and the FIFO holds 2
        s0.aw_valid = 1'b0;
        m.w_ready = 1'b1;
        tick(); tick();
        m.w_ready = 1'b0;
        chk("pre_rst_w_count", 32'(dbg_w_count), 2);
        m.ar_ready = 1'b1;
        s1.ar_valid = 1'b1;
        tick(); tick();
        s1.ar_valid = 1'b0;
        chk("pre_rst_rd_out", 32'(dbg_rd_out), 1);
        m.ar_ready = 1'b0; m.aw_ready = 1'b0;
        s0.ar_valid = 1'b1; s1.ar_valid = 1'b1; s0.aw_valid = 1'b1;
        tick();
        chk("pre_rst_ar_hold", 32'(dbg_ar_state), 1);
        chk("pre_rst_aw_hold", 32'(dbg_aw_state), 1);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        s0.aw_valid = 1'b0;
        chk("post_rst_ar_valid", 32'(m.ar_valid), 0);
        chk("post_rst_aw_valid", 32'(m.aw_valid), 0);
        chk("post_rst_w_valid", 32'(m.w_valid), 0);
        chk("post_rst_w_count", 32'(dbg_w_count), 0);
        chk("post_rst_rd_out", 32'(dbg_rd_out), 0);
        m.ar_ready = 1'b1;
        exp_q.push_back(32'h03);
        ar_collect(1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // hard stop in case a wait ever misbehaves
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end
endmodule
